// File: rtl/drop_seq_pkg.sv
// Shared constants for the drop sequencer: sample width, FSM state
// encoding and the accumulator sizing rule.
package drop_seq_pkg;

    localparam int SAMPLE_W = 16;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ACQUIRE = 3'd1;
    localparam logic [2:0] ST_CHECK   = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_LOCKOUT = 3'd4;
    localparam logic [2:0] ST_FAULT   = 3'd5;

    // Wide enough to sum a full batch of worst-case samples without overflow.
    function automatic int acc_width(input int log2_samples);
        return SAMPLE_W + log2_samples;
    endfunction

endpackage

// File: rtl/drop_sequencer_if.sv
// Sensor handshake plus pilot/display signals of the drop sequencer.
// master: sensor/pilot side, slave: the sequencer.
interface drop_sequencer_if;
    import drop_seq_pkg::*;

    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample_data;
    logic                sample_ready;
    logic [SAMPLE_W-1:0] t_lim;
    logic                arm;
    logic [SAMPLE_W-1:0] t_act;
    logic                drop_en;
    logic                drop_done;
    logic                fault;
    logic [2:0]          state;

    modport master (
        output sample_valid, sample_data, t_lim, arm,
        input  sample_ready, t_act, drop_en, drop_done, fault, state
    );

    modport slave (
        input  sample_valid, sample_data, t_lim, arm,
        output sample_ready, t_act, drop_en, drop_done, fault, state
    );

endinterface

// File: rtl/sample_averager.sv
// Batch accumulator: sums 2**LOG2_SAMPLES accepted samples and presents the
// truncated average of the complete batch alongside the last sample.
module sample_averager
    import drop_seq_pkg::*;
#(
    parameter int LOG2_SAMPLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                accept,
    input  logic [SAMPLE_W-1:0] data,
    output logic                last,
    output logic [SAMPLE_W-1:0] avg
);

    localparam int ACC_W = acc_width(LOG2_SAMPLES);
    localparam int CNT_W = (LOG2_SAMPLES > 0) ? LOG2_SAMPLES : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_SAMPLES) - 1);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;

    // sum includes the sample being accepted, so avg is valid with the last one
    assign sum  = acc + ACC_W'(data);
    assign last = (cnt == CNT_LAST);
    assign avg  = SAMPLE_W'(sum >> LOG2_SAMPLES);

    // accumulate accepted samples; a finished batch restarts from zero
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            if (last) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/drop_sequencer.sv
// Drop sequencer: averages sensor batches into t_act and issues a timed drop
// request after CONFIRM_CNT consecutive armed batches below t_lim.
// Optional sample watchdog: define DROP_SEQ_TIMEOUT_EN.
//
//   state   | meaning
//   IDLE    | clear batch, go acquire
//   ACQUIRE | accept samples until batch complete
//   CHECK   | compare t_act to t_lim, update confirm count
//   RELEASE | drop_en high for HOLD_CYCLES
//   LOCKOUT | wait for pilot disarm
//   FAULT   | watchdog tripped, wait for disarm
module drop_sequencer
    import drop_seq_pkg::*;
#(
    parameter int LOG2_SAMPLES   = 2,
    parameter int CONFIRM_CNT    = 3,
    parameter int HOLD_CYCLES    = 50,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    drop_sequencer_if.slave  bus
);

    localparam int CONF_W = $clog2(CONFIRM_CNT + 1);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CONF_W-1:0] CONF_MAX = CONF_W'(CONFIRM_CNT);

    logic [2:0]          state;
    logic [2:0]          next_state;
    logic [CONF_W-1:0]   confirm;
    logic [CONF_W-1:0]   confirm_inc;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [SAMPLE_W-1:0] t_act_r;
    logic                ready_r;
    logic                drop_en_r;
    logic                drop_done_r;
    logic                accept;
    logic                last;
    logic                clear;
    logic                below;
    logic                wd_expired;
    logic [SAMPLE_W-1:0] avg;

    assign accept      = bus.sample_valid && ready_r;
    assign clear       = (state == ST_IDLE) || (state == ST_CHECK);
    assign below       = bus.arm && (t_act_r < bus.t_lim);
    assign confirm_inc = confirm + 1'b1;

    sample_averager #(
        .LOG2_SAMPLES(LOG2_SAMPLES)
    ) u_avg (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .accept (accept),
        .data   (bus.sample_data),
        .last   (last),
        .avg    (avg)
    );

`ifdef DROP_SEQ_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WD_W-1:0] wd_cnt;
    logic            fault_r;

    assign wd_expired = (state == ST_ACQUIRE) && !accept && (wd_cnt == '0);

    // watchdog: reload outside ACQUIRE and on every accepted sample
    always_ff @(posedge clk) begin
        if (rst || (state != ST_ACQUIRE) || accept) begin
            wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
        end else if (wd_cnt != '0) begin
            wd_cnt <= wd_cnt - 1'b1;
        end
    end

    // fault flag mirrors residency in FAULT
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_r <= 1'b0;
        end else begin
            fault_r <= (next_state == ST_FAULT);
        end
    end

    assign bus.fault = fault_r;
`else
    assign wd_expired = 1'b0;
    assign bus.fault  = 1'b0;
`endif

    // next-state decode
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    next_state = ST_ACQUIRE;
            ST_ACQUIRE: begin
                if (accept && last) begin
                    next_state = ST_CHECK;
                end else if (wd_expired) begin
                    next_state = ST_FAULT;
                end
            end
            ST_CHECK: begin
                if (below && (confirm_inc == CONF_MAX)) begin
                    next_state = ST_RELEASE;
                end else begin
                    next_state = ST_ACQUIRE;
                end
            end
            ST_RELEASE: begin
                if (hold_cnt == '0) begin
                    next_state = ST_LOCKOUT;
                end
            end
            ST_LOCKOUT: begin
                if (!bus.arm) begin
                    next_state = ST_IDLE;
                end
            end
`ifdef DROP_SEQ_TIMEOUT_EN
            ST_FAULT: begin
                if (!bus.arm) begin
                    next_state = ST_IDLE;
                end
            end
`endif
            default:    next_state = ST_IDLE;
        endcase
    end

    // state, registered outputs and confirm/hold counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            ready_r     <= 1'b0;
            drop_en_r   <= 1'b0;
            drop_done_r <= 1'b0;
            t_act_r     <= '0;
            confirm     <= '0;
            hold_cnt    <= '0;
        end else begin
            state       <= next_state;
            ready_r     <= (next_state == ST_ACQUIRE);
            drop_en_r   <= (next_state == ST_RELEASE);
            drop_done_r <= (state == ST_RELEASE) && (next_state == ST_LOCKOUT);

            if (accept && last) begin
                t_act_r <= avg;
            end

            if (state == ST_CHECK) begin
                confirm <= below ? confirm_inc : '0;
            end else if ((state == ST_RELEASE && next_state == ST_LOCKOUT) ||
                         (state == ST_FAULT)) begin
                confirm <= '0;
            end

            if (state == ST_CHECK) begin
                hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
            end else if (state == ST_RELEASE && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

    assign bus.sample_ready = ready_r;
    assign bus.t_act        = t_act_r;
    assign bus.drop_en      = drop_en_r;
    assign bus.drop_done    = drop_done_r;
    assign bus.state        = state;

endmodule
